// File: rtl/game_flow_fsm.sv
// -----------------------------------------------------------------------------
// game_flow_fsm
//
// Level/game sequencer that sits after the collision controller. It turns the
// per-pixel gift, hole and loss strobes into game state (gifts remaining,
// per-level countdown, level index, WIN/LOSE screens). It also drives
// gift_clear and finishCount back into the collision controller.
//
// Parameters
//   GIFTS_PER_LEVEL  gifts loaded at each level start (1..15)
//   TIME_LIMIT       seconds per level (1..99)
//   FRAMES_PER_SEC   startOfFrame pulses per second
//   NUM_LEVELS       number of levels (1..4)
//   WIN_HOLD_FRAMES  frames the level-complete screen is held
//
// Ports
//   clk           system clock
//   resetN        asynchronous active-low reset
//   startOfFrame  one-cycle pulse at frame start
//   startKey      debounced one-cycle start pulse
//   Remove_Gift   ball-over-gift strobe; may stay high for many pixels
//   victory       ball-over-hole strobe
//   Loss          out-of-map / timeout strobe
//   gift_clear    no gifts remain in the current level (PLAY only)
//   finishCount   countdown expired (PLAY only)
//   gameState     00 IDLE, 01 PLAY, 10 WIN, 11 LOSE
//   playEnable    high only in PLAY
//   giftsLeft     gifts remaining
//   timeLeft      seconds remaining
//   level         current level, 0-based
//   gameWon       final level completed
// -----------------------------------------------------------------------------
module game_flow_fsm #(
   parameter int GIFTS_PER_LEVEL = 4,
   parameter int TIME_LIMIT      = 60,
   parameter int FRAMES_PER_SEC  = 30,
   parameter int NUM_LEVELS      = 3,
   parameter int WIN_HOLD_FRAMES = 60
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic       startKey,
   input  logic       Remove_Gift,
   input  logic       victory,
   input  logic       Loss,
   output logic       gift_clear,
   output logic       finishCount,
   output logic [1:0] gameState,
   output logic       playEnable,
   output logic [3:0] giftsLeft,
   output logic [6:0] timeLeft,
   output logic [1:0] level,
   output logic       gameWon
);

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_PLAY = 2'b01;
   localparam logic [1:0] ST_WIN  = 2'b10;
   localparam logic [1:0] ST_LOSE = 2'b11;

   // Counter widths: frame counter holds 0..FRAMES_PER_SEC-1, hold counter
   // holds 0..WIN_HOLD_FRAMES-1.
   localparam int FRAME_W = (FRAMES_PER_SEC  > 1) ? $clog2(FRAMES_PER_SEC)  : 1;
   localparam int HOLD_W  = (WIN_HOLD_FRAMES > 1) ? $clog2(WIN_HOLD_FRAMES) : 1;

   localparam logic [3:0]         GIFT_LOAD  = 4'(GIFTS_PER_LEVEL);
   localparam logic [6:0]         TIME_LOAD  = 7'(TIME_LIMIT);
   localparam logic [1:0]         LAST_LEVEL = 2'(NUM_LEVELS - 1);
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_SEC - 1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(WIN_HOLD_FRAMES - 1);

   // State registers
   logic [1:0]         state_q,     state_d;
   logic [1:0]         level_q,     level_d;
   logic [3:0]         gifts_q,     gifts_d;
   logic [6:0]         time_q,      time_d;
   logic [FRAME_W-1:0] frame_q,     frame_d;
   logic [HOLD_W-1:0]  hold_q,      hold_d;
   logic               gift_flag_q, gift_flag_d;
   logic               game_won_q,  game_won_d;

   // Values the PLAY-state datapath would load this cycle
   logic               in_play;
   logic               flag_eff;
   logic               remove_evt;
   logic [3:0]         gifts_play;
   logic               flag_play;
   logic [FRAME_W-1:0] frame_play;
   logic [6:0]         time_play;

   // ---------------------------------------------------------------------------
   // Outputs: purely from registers so the collision controller sees stable
   // gating for the whole cycle.
   // ---------------------------------------------------------------------------
   assign in_play     = (state_q == ST_PLAY);
   assign gift_clear  = in_play && (gifts_q == 4'd0);
   assign finishCount = in_play && (time_q == 7'd0);
   assign gameState   = state_q;
   assign playEnable  = in_play;
   assign giftsLeft   = gifts_q;
   assign timeLeft    = time_q;
   assign level       = level_q;
   assign gameWon     = game_won_q;

   // ---------------------------------------------------------------------------
   // Gift removal. The flag is treated as already cleared in a startOfFrame
   // cycle, so a removal coinciding with the frame pulse still counts and
   // re-arms the flag for the rest of that frame.
   // ---------------------------------------------------------------------------
   always_comb begin
      flag_eff   = gift_flag_q & ~startOfFrame;
      remove_evt = Remove_Gift & ~flag_eff & (gifts_q != 4'd0);
      gifts_play = remove_evt ? (gifts_q - 4'd1) : gifts_q;
      flag_play  = flag_eff | remove_evt;
   end

   // ---------------------------------------------------------------------------
   // Countdown: frame counter wraps once per second and steps timeLeft down,
   // saturating at zero. The frame counter keeps wrapping after timeout.
   // ---------------------------------------------------------------------------
   always_comb begin
      frame_play = frame_q;
      time_play  = time_q;
      if (startOfFrame) begin
         if (frame_q == FRAME_LAST) begin
            frame_play = '0;
            if (time_q != 7'd0) begin
               time_play = time_q - 7'd1;
            end
         end else begin
            frame_play = frame_q + FRAME_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Game-flow state machine
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      level_d     = level_q;
      gifts_d     = gifts_q;
      time_d      = time_q;
      frame_d     = frame_q;
      hold_d      = hold_q;
      gift_flag_d = gift_flag_q;
      game_won_d  = game_won_q;

      case (state_q)
         ST_IDLE: begin
            // Counters already sit at their load values here; they are
            // reloaded again on the way into PLAY for clarity.
            if (startKey) begin
               state_d     = ST_PLAY;
               level_d     = 2'd0;
               gifts_d     = GIFT_LOAD;
               time_d      = TIME_LOAD;
               frame_d     = '0;
               gift_flag_d = 1'b0;
            end
         end

         ST_PLAY: begin
            // Datapath keeps running in the exit cycle; the screens freeze it.
            gifts_d     = gifts_play;
            gift_flag_d = flag_play;
            frame_d     = frame_play;
            time_d      = time_play;

            // Loss has priority over a simultaneous victory. Victory only
            // counts once gift_clear is already visible from the registers.
            if (Loss) begin
               state_d = ST_LOSE;
            end else if (victory && gift_clear) begin
               state_d = ST_WIN;
               hold_d  = '0;
               if (level_q == LAST_LEVEL) begin
                  game_won_d = 1'b1;
               end
            end
         end

         ST_WIN: begin
            if (level_q != LAST_LEVEL) begin
               // Level-complete screen: advance after WIN_HOLD_FRAMES pulses.
               if (startOfFrame) begin
                  if (hold_q == HOLD_LAST) begin
                     state_d     = ST_PLAY;
                     level_d     = level_q + 2'd1;
                     gifts_d     = GIFT_LOAD;
                     time_d      = TIME_LOAD;
                     frame_d     = '0;
                     gift_flag_d = 1'b0;
                     hold_d      = '0;
                  end else begin
                     hold_d = hold_q + HOLD_W'(1);
                  end
               end
            end else if (startKey) begin
               // Game completed: wait on the final screen for a restart.
               state_d     = ST_IDLE;
               level_d     = 2'd0;
               gifts_d     = GIFT_LOAD;
               time_d      = TIME_LOAD;
               frame_d     = '0;
               gift_flag_d = 1'b0;
               hold_d      = '0;
               game_won_d  = 1'b0;
            end
         end

         ST_LOSE: begin
            if (startKey) begin
               state_d     = ST_IDLE;
               level_d     = 2'd0;
               gifts_d     = GIFT_LOAD;
               time_d      = TIME_LOAD;
               frame_d     = '0;
               gift_flag_d = 1'b0;
               hold_d      = '0;
               game_won_d  = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= ST_IDLE;
         level_q     <= 2'd0;
         gifts_q     <= GIFT_LOAD;
         time_q      <= TIME_LOAD;
         frame_q     <= '0;
         hold_q      <= '0;
         gift_flag_q <= 1'b0;
         game_won_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         gifts_q     <= gifts_d;
         time_q      <= time_d;
         frame_q     <= frame_d;
         hold_q      <= hold_d;
         gift_flag_q <= gift_flag_d;
         game_won_q  <= game_won_d;
      end
   end

endmodule
